plb_bram_port_master: RTL and testbench

Initiator for one port of the dual-port BRAM block. It turns word-granular read and write burst requests (valid/ready) into the BRAM port signals EN, WEN, Addr and Dout. It captures read data from BRAM_Din one cycle after each enable, and returns it through a small response FIFO with backpressure. It sits between the PLB-side slave logic and BRAM port A or B.

---
 rtl/plb_bram_port_pkg.sv | 22 ++
 rtl/plb_bram_port_master_rsp_fifo.sv | 51 +++++
 rtl/plb_bram_port_master.sv | 135 +++++++++++++
 tb/tb_plb_bram_port_master.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plb_bram_port_pkg.sv
// Shared constants and helpers for the PLB-side BRAM port master.
// State encodings stay plain localparams so the controller stays portable to older flows.
package plb_bram_port_pkg;

   localparam int BEAT_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RD   = 2'd1;
   localparam state_t ST_WR   = 2'd2;

   // Number of low address bits that select a byte within one port word.
   function automatic int lane_ofs(input int num_we);
      return $clog2(num_we);
   endfunction

   function automatic logic [63:0] offset_mask(input longint memsize);
      return 64'(memsize - 1);
   endfunction

endpackage

// File: rtl/plb_bram_port_master_rsp_fifo.sv
// Response FIFO for read beats: {data, last}, with occupancy count for read credits.
module plb_bram_port_rsp_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/plb_bram_port_master.sv
// Burst initiator for one BRAM port: word bursts in, EN/WEN/Addr/Dout out,
// read data returned through a credit-protected response FIFO.
module plb_bram_port_master
   import plb_bram_port_pkg::*;
#(
   parameter int C_PORT_DWIDTH = 64,
   parameter int C_PORT_AWIDTH = 32,
   parameter int C_NUM_WE      = 8,
   parameter int C_MEMSIZE     = 'h4000,
   parameter int C_RSP_DEPTH   = 4
) (
   input  logic                     BRAM_Clk,
   input  logic                     BRAM_Rst,
   input  logic                     Req_Valid,
   output logic                     Req_Ready,
   input  logic                     Req_RNW,
   input  logic [0:C_PORT_AWIDTH-1] Req_Addr,
   input  logic [BEAT_W-1:0]        Req_Len,
   input  logic                     Wr_Valid,
   output logic                     Wr_Ready,
   input  logic [0:C_PORT_DWIDTH-1] Wr_Data,
   input  logic [0:C_NUM_WE-1]      Wr_BE,
   output logic                     Rd_Valid,
   input  logic                     Rd_Ready,
   output logic [0:C_PORT_DWIDTH-1] Rd_Data,
   output logic                     Rd_Last,
   output logic                     Busy,
   output logic                     BRAM_EN,
   output logic [0:C_NUM_WE-1]      BRAM_WEN,
   output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
   output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
   input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

   localparam int CW     = $clog2(C_RSP_DEPTH) + 1;
   localparam int L_LANE = lane_ofs(C_NUM_WE);
   localparam logic [0:C_PORT_AWIDTH-1] L_ALIGN = ~C_PORT_AWIDTH'((1 << L_LANE) - 1);
   localparam logic [0:C_PORT_AWIDTH-1] L_OFS   = C_PORT_AWIDTH'(offset_mask(C_MEMSIZE));

   state_t                     r_state;
   logic [0:C_PORT_AWIDTH-1]   r_addr;
   logic [0:C_PORT_AWIDTH-1]   r_addr_hold;
   logic [BEAT_W-1:0]          r_beats;
   logic                       r_inflight;
   logic                       r_inflight_last;

   logic                       w_req_fire;
   logic                       w_last_beat;
   logic                       w_issue_rd;
   logic                       w_issue_wr;
   logic                       w_issue;
   logic [CW:0]                w_credit;
   logic [0:C_PORT_AWIDTH-1]   w_addr_next;
   logic [CW-1:0]              w_fifo_count;
   logic                       w_fifo_empty;
   logic [C_PORT_DWIDTH:0]     w_fifo_head;
   logic                       w_pop;

   assign Req_Ready   = (r_state == ST_IDLE) && !BRAM_Rst;
   assign w_req_fire  = Req_Valid && Req_Ready;
   assign w_last_beat = (r_beats == '0);

   // Credits count both queued beats and the one whose data is still on BRAM_Din.
   assign w_credit   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue_rd = (r_state == ST_RD) && (w_credit < (CW + 1)'(C_RSP_DEPTH));
   assign w_issue_wr = (r_state == ST_WR) && Wr_Valid;
   assign w_issue    = w_issue_rd || w_issue_wr;

   // Offset field wraps inside the memory; bits above it keep the start value.
   assign w_addr_next = (r_addr & ~L_OFS) |
                        ((r_addr + C_PORT_AWIDTH'(C_NUM_WE)) & L_OFS);

   assign Wr_Ready  = (r_state == ST_WR);
   assign BRAM_EN   = w_issue;
   assign BRAM_WEN  = w_issue_wr ? Wr_BE : '0;
   assign BRAM_Dout = w_issue_wr ? Wr_Data : '0;
   assign BRAM_Addr = w_issue ? r_addr : r_addr_hold;

   always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
      if (BRAM_Rst) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_addr_hold     <= '0;
         r_beats         <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue_rd;
         r_inflight_last <= w_issue_rd && w_last_beat;
         if (w_issue) r_addr_hold <= r_addr;
         case (r_state)
            ST_IDLE: begin
               if (w_req_fire) begin
                  r_addr  <= Req_Addr & L_ALIGN;
                  r_beats <= Req_Len;
                  r_state <= Req_RNW ? ST_RD : ST_WR;
               end
            end
            ST_RD, ST_WR: begin
               if (w_issue) begin
                  if (w_last_beat) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_beats <= r_beats - 1'b1;
                     r_addr  <= w_addr_next;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_pop = Rd_Valid && Rd_Ready;

   plb_bram_port_rsp_fifo #(
      .W     (C_PORT_DWIDTH + 1),
      .DEPTH (C_RSP_DEPTH)
   ) u_rsp_fifo (
      .i_clk   (BRAM_Clk),
      .i_rst   (BRAM_Rst),
      .i_push  (r_inflight),
      .i_data  ({BRAM_Din, r_inflight_last}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign Rd_Valid = !w_fifo_empty;
   assign Rd_Data  = Rd_Valid ? w_fifo_head[C_PORT_DWIDTH:1] : '0;
   assign Rd_Last  = Rd_Valid && w_fifo_head[0];
   assign Busy     = (r_state != ST_IDLE) || r_inflight || !w_fifo_empty;

endmodule

// File: tb/tb_plb_bram_port_master.sv
// Directed bench for plb_bram_port_master with a behavioural BRAM port model.
module tb_plb_bram_port_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Req_Valid = 1'b0, Req_Ready, Req_RNW = 1'b0;
   logic [0:31] Req_Addr = '0;
   logic [3:0]  Req_Len = '0;
   logic        Wr_Valid = 1'b0, Wr_Ready;
   logic [0:63] Wr_Data = '0;
   logic [0:7]  Wr_BE = '0;
   logic        Rd_Valid, Rd_Ready = 1'b0, Rd_Last, Busy;
   logic [0:63] Rd_Data;
   logic        BRAM_EN;
   logic [0:7]  BRAM_WEN;
   logic [0:31] BRAM_Addr;
   logic [0:63] BRAM_Dout;
   logic [0:63] BRAM_Din = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [0:63] mem [logic [31:0]];
   logic [31:0] en_addr_q[$];
   logic [0:7]  en_wen_q[$];
   logic [0:63] en_dout_q[$];
   int          en_cyc_q[$];
   logic [0:63] rd_data_q[$];
   logic        rd_last_q[$];
   int          rd_cyc_q[$];

   plb_bram_port_master dut (
      .BRAM_Clk(clk), .BRAM_Rst(rst),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_RNW(Req_RNW),
      .Req_Addr(Req_Addr), .Req_Len(Req_Len),
      .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data), .Wr_BE(Wr_BE),
      .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
      .Busy(Busy), .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
      .BRAM_Dout(BRAM_Dout), .BRAM_Din(BRAM_Din)
   );

   always #5 clk = ~clk;

   function automatic logic [0:63] pat(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: byte-lane writes, registered read data.
   always @(posedge clk) begin
      logic [31:0] a;
      logic [0:63] w;
      if (BRAM_EN) begin
         a = BRAM_Addr;
         w = mem.exists(a) ? mem[a] : pat(a);
         if (BRAM_WEN != '0) begin
            for (int i = 0; i < 8; i++)
               if (BRAM_WEN[i]) w[8*i +: 8] = BRAM_Dout[8*i +: 8];
            mem[a] = w;
         end else begin
            BRAM_Din <= w;
         end
      end
   end

   // Cycle labels: cycle c+1 is the one following edge c.
   always @(negedge clk) begin
      if (BRAM_EN) begin
         en_addr_q.push_back(BRAM_Addr);
         en_wen_q.push_back(BRAM_WEN);
         en_dout_q.push_back(BRAM_Dout);
         en_cyc_q.push_back(cyc + 1);
      end
      if (Rd_Valid && Rd_Ready) begin
         rd_data_q.push_back(Rd_Data);
         rd_last_q.push_back(Rd_Last);
         rd_cyc_q.push_back(cyc + 1);
      end
   end

   task automatic clear_q();
      en_addr_q.delete(); en_wen_q.delete(); en_dout_q.delete(); en_cyc_q.delete();
      rd_data_q.delete(); rd_last_q.delete(); rd_cyc_q.delete();
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_req(input logic rnw, input logic [31:0] addr, input logic [3:0] len,
                           output int k);
      int n = 0;
      Req_Valid = 1'b1; Req_RNW = rnw; Req_Addr = addr; Req_Len = len;
      while (!Req_Ready && n < 50) begin step(1); n++; end
      n_cmp++;
      if (!Req_Ready) begin
         n_bad++;
         $display("FAIL req_accept_timeout got ready=%0b need 1", Req_Ready);
      end
      @(posedge clk); #1;
      k = cyc;
      Req_Valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({Req_Ready, Wr_Ready, Rd_Valid, Rd_Last, Busy, BRAM_EN} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got %b need 000000",
                  {Req_Ready, Wr_Ready, Rd_Valid, Rd_Last, Busy, BRAM_EN});
      end
      n_cmp++;
      if (BRAM_WEN !== 8'h00 || BRAM_Addr !== 32'h0 || BRAM_Dout !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_bram got wen=%h addr=%h dout=%h need all 0",
                  BRAM_WEN, BRAM_Addr, BRAM_Dout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (Req_Ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready got %b need 1", Req_Ready);
      end
   endtask

   task automatic test_single_read();
      int k;
      step(1);
      Rd_Ready = 1'b1;
      mem[32'h10] = 64'h0123_4567_89AB_CDEF;
      clear_q();
      send_req(1'b1, 32'h10, 4'd0, k);
      step(6);
      n_cmp++;
      if (en_addr_q.size() != 1 || en_addr_q[0] !== 32'h10 || en_cyc_q[0] != k + 1
          || en_wen_q[0] !== 8'h00) begin
         n_bad++;
         $display("FAIL single_rd_en got n=%0d addr=%h cyc=%0d need n=1 addr=10 cyc=%0d",
                  en_addr_q.size(), en_addr_q.size() ? en_addr_q[0] : 0,
                  en_cyc_q.size() ? en_cyc_q[0] : 0, k + 1);
      end
      n_cmp++;
      if (rd_data_q.size() != 1 || rd_data_q[0] !== 64'h0123_4567_89AB_CDEF
          || rd_last_q[0] !== 1'b1 || rd_cyc_q[0] != k + 3) begin
         n_bad++;
         $display("FAIL single_rd_rsp got n=%0d data=%h cyc=%0d need n=1 data=0123456789abcdef last=1 cyc=%0d",
                  rd_data_q.size(), rd_data_q.size() ? rd_data_q[0] : 64'h0,
                  rd_cyc_q.size() ? rd_cyc_q[0] : 0, k + 3);
      end
      n_cmp++;
      if (Busy !== 1'b0) begin
         n_bad++;
         $display("FAIL single_rd_idle_busy got %b need 0", Busy);
      end
   endtask

   task automatic test_write_burst();
      int k;
      clear_q();
      send_req(1'b0, 32'h100, 4'd3, k);
      for (int i = 0; i < 4; i++) begin
         Wr_Valid = 1'b1; Wr_BE = 8'hFF; Wr_Data = 64'(i + 1);
         step(1);
      end
      Wr_Valid = 1'b0;
      step(2);
      n_cmp++;
      if (en_addr_q.size() != 4) begin
         n_bad++;
         $display("FAIL wr_burst_count got %0d need 4", en_addr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (en_addr_q[i] !== 32'h100 + 32'(8 * i) || en_wen_q[i] !== 8'hFF
                || en_dout_q[i] !== 64'(i + 1) || en_cyc_q[i] != k + 1 + i) begin
               n_bad++;
               $display("FAIL wr_burst_beat%0d got addr=%h wen=%h dout=%h cyc=%0d need addr=%h wen=ff dout=%0d cyc=%0d",
                        i, en_addr_q[i], en_wen_q[i], en_dout_q[i], en_cyc_q[i],
                        32'h100 + 32'(8 * i), i + 1, k + 1 + i);
            end
         end
      end
      // Read back the second written word.
      clear_q();
      send_req(1'b1, 32'h108, 4'd0, k);
      step(6);
      n_cmp++;
      if (rd_data_q.size() != 1 || rd_data_q[0] !== 64'd2) begin
         n_bad++;
         $display("FAIL wr_readback got n=%0d data=%h need n=1 data=2",
                  rd_data_q.size(), rd_data_q.size() ? rd_data_q[0] : 64'h0);
      end
   endtask

   task automatic test_back_to_back_stall();
      int k, n;
      Rd_Ready = 1'b0;
      clear_q();
      send_req(1'b1, 32'h200, 4'd15, k);
      step(10);
      n_cmp++;
      if (en_addr_q.size() != 4) begin
         n_bad++;
         $display("FAIL stall_en_count got %0d need 4", en_addr_q.size());
      end
      n_cmp++;
      if (Rd_Valid !== 1'b1 || Rd_Data !== pat(32'h200) || Rd_Last !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_head got valid=%b data=%h last=%b need 1 %h 0",
                  Rd_Valid, Rd_Data, Rd_Last, pat(32'h200));
      end
      Rd_Ready = 1'b1;
      n = 0;
      while (rd_data_q.size() < 16 && n < 60) begin step(1); n++; end
      step(2);
      n_cmp++;
      if (rd_data_q.size() != 16 || en_addr_q.size() != 16) begin
         n_bad++;
         $display("FAIL stall_beats got rd=%0d en=%0d need 16 16",
                  rd_data_q.size(), en_addr_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rd_data_q[i] !== pat(32'h200 + 32'(8 * i)) || rd_last_q[i] !== (i == 15)) begin
               n_bad++;
               $display("FAIL stall_beat%0d got data=%h last=%b need %h %b",
                        i, rd_data_q[i], rd_last_q[i], pat(32'h200 + 32'(8 * i)), i == 15);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int k;
      logic [31:0] exp_a [4];
      exp_a = '{32'h8000_3FF0, 32'h8000_3FF8, 32'h8000_0000, 32'h8000_0008};
      clear_q();
      send_req(1'b1, 32'h8000_3FF0, 4'd3, k);
      step(8);
      n_cmp++;
      if (en_addr_q.size() != 4 || rd_data_q.size() != 4) begin
         n_bad++;
         $display("FAIL wrap_count got en=%0d rd=%0d need 4 4", en_addr_q.size(), rd_data_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (en_addr_q[i] !== exp_a[i] || rd_data_q[i] !== pat(exp_a[i])) begin
               n_bad++;
               $display("FAIL wrap_beat%0d got addr=%h data=%h need addr=%h data=%h",
                        i, en_addr_q[i], rd_data_q[i], exp_a[i], pat(exp_a[i]));
            end
         end
      end
   endtask

   task automatic test_write_gaps();
      int k, j;
      logic vp [6];
      int exp_c [3];
      logic [0:63] exp_w;
      vp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      clear_q();
      send_req(1'b0, 32'h25, 4'd2, k);
      exp_c = '{k + 1, k + 3, k + 6};
      for (int i = 0; i < 6; i++) begin
         Wr_Valid = vp[i]; Wr_BE = 8'h80;
         Wr_Data = 64'hDE00_0000_0000_0000 | 64'(i);
         step(1);
      end
      Wr_Valid = 1'b0;
      step(2);
      n_cmp++;
      if (en_addr_q.size() != 3) begin
         n_bad++;
         $display("FAIL gap_count got %0d need 3", en_addr_q.size());
      end else begin
         for (j = 0; j < 3; j++) begin
            n_cmp++;
            if (en_addr_q[j] !== 32'h20 + 32'(8 * j) || en_wen_q[j] !== 8'b1000_0000
                || en_cyc_q[j] != exp_c[j]) begin
               n_bad++;
               $display("FAIL gap_beat%0d got addr=%h wen=%b cyc=%0d need addr=%h wen=10000000 cyc=%0d",
                        j, en_addr_q[j], en_wen_q[j], en_cyc_q[j], 32'h20 + 32'(8 * j), exp_c[j]);
            end
         end
      end
      exp_w = pat(32'h20);
      exp_w[0:7] = 8'hDE;
      clear_q();
      send_req(1'b1, 32'h20, 4'd0, k);
      step(6);
      n_cmp++;
      if (rd_data_q.size() != 1 || rd_data_q[0] !== exp_w) begin
         n_bad++;
         $display("FAIL gap_readback got n=%0d data=%h need %h",
                  rd_data_q.size(), rd_data_q.size() ? rd_data_q[0] : 64'h0, exp_w);
      end
   endtask

   task automatic test_reset_mid_burst();
      int k, n;
      Rd_Ready = 1'b1;
      clear_q();
      send_req(1'b1, 32'h400, 4'd15, k);
      n = 0;
      while (en_addr_q.size() < 5 && n < 30) begin @(negedge clk); #1; n++; end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (BRAM_EN !== 1'b0 || Rd_Valid !== 1'b0 || Req_Ready !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_assert got en=%b rdv=%b rdy=%b need 0 0 0",
                  BRAM_EN, Rd_Valid, Req_Ready);
      end
      step(2);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (Req_Ready !== 1'b1 || Rd_Valid !== 1'b0 || en_addr_q.size() != 5) begin
         n_bad++;
         $display("FAIL midrst_release got rdy=%b rdv=%b en_count=%0d need 1 0 5",
                  Req_Ready, Rd_Valid, en_addr_q.size());
      end
      step(1);
      clear_q();
      send_req(1'b1, 32'h10, 4'd0, k);
      step(6);
      n_cmp++;
      if (rd_data_q.size() != 1 || rd_data_q[0] !== 64'h0123_4567_89AB_CDEF || rd_last_q[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_fresh_read got n=%0d data=%h need n=1 data=0123456789abcdef",
                  rd_data_q.size(), rd_data_q.size() ? rd_data_q[0] : 64'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got time=%0t need finish earlier", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_read();
      test_write_burst();
      test_back_to_back_stall();
      test_wrap();
      test_write_gaps();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
